// File: rtl/dsi_lp_pkg.sv
// Shared LP line-state definitions for the DSI escape-mode receive and transmit lanes.
package dsi_lp_pkg;

    // Encoding is {Dp, Dn}
    typedef enum logic [1:0] {
        LP00 = 2'b00,
        LP01 = 2'b01,
        LP10 = 2'b10,
        LP11 = 2'b11
    } lp_line_t;

    // Escape entry after leaving LP-11: LP-10, LP-00, LP-01, LP-00
    localparam logic [7:0] ESC_MODE_ENTRY = 8'b10_00_01_00;
    localparam logic [7:0] ENTRY_CMD_LPDT = 8'hE1;

    typedef enum logic [2:0] {
        ST_DISABLED,
        ST_STOP,
        ST_ESC_RQST,
        ST_ESC_BRIDGE,
        ST_ESC_ACK,
        ST_CMD,
        ST_DATA,
        ST_WAIT_STOP
    } esc_state_t;

    function automatic lp_line_t entry_step(input logic [1:0] idx);
        case (idx)
            2'd0:    entry_step = lp_line_t'(ESC_MODE_ENTRY[7:6]);
            2'd1:    entry_step = lp_line_t'(ESC_MODE_ENTRY[5:4]);
            2'd2:    entry_step = lp_line_t'(ESC_MODE_ENTRY[3:2]);
            default: entry_step = lp_line_t'(ESC_MODE_ENTRY[1:0]);
        endcase
    endfunction

endpackage

// File: rtl/dsi_lp_esc_receiver_if.sv
// Receive-side results of the LP escape receiver as seen by the packet layer.
interface dsi_lp_esc_receiver_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] rx_cmd;
    logic       rx_cmd_valid;
    logic       rx_active;
    logic       err_esc;
    logic       err_sync;

    modport master (
        output rx_data, rx_valid, rx_cmd, rx_cmd_valid, rx_active, err_esc, err_sync
    );

    modport slave (
        input  rx_data, rx_valid, rx_cmd, rx_cmd_valid, rx_active, err_esc, err_sync
    );
endinterface

// File: rtl/dsi_lp_line_filter.sv
// Synchronizes the LP pad pair and accepts a new line state only after it has held steadily.
module dsi_lp_line_filter
    import dsi_lp_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 3
) (
    input  logic     clk_sys,
    input  logic     rst,
    input  logic     lp_p,
    input  logic     lp_n,
    output lp_line_t line_state,
    output logic     line_event
);
    localparam int CW = $clog2(FILTER_CYCLES + 1);

    logic [SYNC_STAGES-1:0][1:0] sync_q;
    lp_line_t                    synced;
    lp_line_t                    cand;
    logic [CW-1:0]               stable_cnt;
    logic [CW-1:0]               next_cnt;

    assign synced   = lp_line_t'(sync_q[SYNC_STAGES-1]);
    assign next_cnt = (synced == cand) ? stable_cnt + CW'(1) : CW'(1);

    // Synchronizer resets to LP-11 so a released reset never looks like an edge
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            sync_q     <= '1;
            cand       <= LP11;
            stable_cnt <= '0;
            line_state <= LP11;
            line_event <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], lp_p, lp_n};
            cand       <= synced;
            line_event <= 1'b0;
            if (synced == line_state) begin
                stable_cnt <= '0;
            end else if (next_cnt == CW'(FILTER_CYCLES)) begin
                line_state <= synced;
                line_event <= 1'b1;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= next_cnt;
            end
        end
    end
endmodule

// File: rtl/dsi_lp_esc_receiver.sv
// LP escape-mode receiver for one DSI data lane: entry detection, command decode, LPDT byte delivery.
module dsi_lp_esc_receiver
    import dsi_lp_pkg::*;
#(
    parameter int         SYNC_STAGES   = 2,
    parameter int         FILTER_CYCLES = 3,
    parameter logic [7:0] LPDT_CMD      = ENTRY_CMD_LPDT
) (
    input  logic                   clk_sys,
    input  logic                   rst,
    input  logic                   lines_enable,
    input  logic                   LP_p_input,
    input  logic                   LP_n_input,
    dsi_lp_esc_receiver_if.master  rx_if
);
    lp_line_t   line_state;
    logic       line_event;
    esc_state_t state;
    logic [2:0] bit_cnt;
    logic [7:0] shift_q;
    logic [7:0] next_shift;
    logic       mark_pending;
    logic       mark_bit;
    logic       in_payload;

    dsi_lp_line_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_filter (
        .clk_sys    (clk_sys),
        .rst        (rst),
        .lp_p       (LP_p_input),
        .lp_n       (LP_n_input),
        .line_state (line_state),
        .line_event (line_event)
    );

    assign next_shift = {shift_q[6:0], mark_bit};
    assign in_payload = (state == ST_CMD) || (state == ST_DATA);

    // A mark (LP-10/LP-01) only arms a bit; the following LP-00 commits it
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state              <= ST_DISABLED;
            bit_cnt            <= '0;
            shift_q            <= '0;
            mark_pending       <= 1'b0;
            mark_bit           <= 1'b0;
            rx_if.rx_data      <= '0;
            rx_if.rx_valid     <= 1'b0;
            rx_if.rx_cmd       <= '0;
            rx_if.rx_cmd_valid <= 1'b0;
            rx_if.rx_active    <= 1'b0;
            rx_if.err_esc      <= 1'b0;
            rx_if.err_sync     <= 1'b0;
        end else begin
            rx_if.rx_valid     <= 1'b0;
            rx_if.rx_cmd_valid <= 1'b0;
            rx_if.err_esc      <= 1'b0;
            rx_if.err_sync     <= 1'b0;
            if (!lines_enable) begin
                state           <= ST_DISABLED;
                bit_cnt         <= '0;
                shift_q         <= '0;
                mark_pending    <= 1'b0;
                rx_if.rx_active <= 1'b0;
            end else if (state == ST_DISABLED) begin
                if (line_state == LP11)
                    state <= ST_STOP;
            end else if (line_event) begin
                if (line_state == LP11) begin
                    if (in_payload && bit_cnt != 3'd0)
                        rx_if.err_sync <= 1'b1;
                    state           <= ST_STOP;
                    bit_cnt         <= '0;
                    shift_q         <= '0;
                    mark_pending    <= 1'b0;
                    rx_if.rx_active <= 1'b0;
                end else begin
                    case (state)
                        ST_STOP: begin
                            if (line_state == entry_step(2'd0)) begin
                                state           <= ST_ESC_RQST;
                                rx_if.rx_active <= 1'b1;
                            end
                        end
                        ST_ESC_RQST: begin
                            if (line_state == entry_step(2'd1)) begin
                                state <= ST_ESC_BRIDGE;
                            end else begin
                                rx_if.err_esc <= 1'b1;
                                state         <= ST_WAIT_STOP;
                            end
                        end
                        ST_ESC_BRIDGE: begin
                            if (line_state == entry_step(2'd2)) begin
                                state <= ST_ESC_ACK;
                            end else begin
                                rx_if.err_esc <= 1'b1;
                                state         <= ST_WAIT_STOP;
                            end
                        end
                        ST_ESC_ACK: begin
                            if (line_state == entry_step(2'd3)) begin
                                state        <= ST_CMD;
                                bit_cnt      <= '0;
                                mark_pending <= 1'b0;
                            end else begin
                                rx_if.err_esc <= 1'b1;
                                state         <= ST_WAIT_STOP;
                            end
                        end
                        ST_CMD, ST_DATA: begin
                            if (line_state == LP00) begin
                                if (mark_pending) begin
                                    mark_pending <= 1'b0;
                                    shift_q      <= next_shift;
                                    bit_cnt      <= bit_cnt + 3'd1;
                                    if (bit_cnt == 3'd7) begin
                                        if (state == ST_CMD) begin
                                            rx_if.rx_cmd       <= next_shift;
                                            rx_if.rx_cmd_valid <= 1'b1;
                                            state <= (next_shift == LPDT_CMD) ? ST_DATA : ST_WAIT_STOP;
                                        end else begin
                                            rx_if.rx_data  <= next_shift;
                                            rx_if.rx_valid <= 1'b1;
                                        end
                                    end
                                end
                            end else if (mark_pending) begin
                                rx_if.err_esc <= 1'b1;
                                state         <= ST_WAIT_STOP;
                            end else begin
                                mark_pending <= 1'b1;
                                mark_bit     <= (line_state == LP10);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_dsi_lp_esc_receiver.sv
// Randomized bench for the LP escape receiver, checked against a symbol-stream reference model.
module tb_dsi_lp_esc_receiver;
    import dsi_lp_pkg::*;

    localparam int         FILTER_CYCLES = 3;
    localparam logic [7:0] LPDT          = 8'hE1;

    logic clk_sys = 1'b0;
    logic rst;
    logic lines_enable;
    logic lp_p;
    logic lp_n;

    dsi_lp_esc_receiver_if rx_if();

    dsi_lp_esc_receiver #(
        .SYNC_STAGES   (2),
        .FILTER_CYCLES (FILTER_CYCLES),
        .LPDT_CMD      (LPDT)
    ) dut (
        .clk_sys      (clk_sys),
        .rst          (rst),
        .lines_enable (lines_enable),
        .LP_p_input   (lp_p),
        .LP_n_input   (lp_n),
        .rx_if        (rx_if)
    );

    always #5 clk_sys = ~clk_sys;

    int         checks = 0;
    int         passes = 0;
    lp_line_t   sent[$];
    lp_line_t   seg[$];
    logic [7:0] tx_bytes[$];
    logic [7:0] act_cmd[$];
    logic [7:0] act_data[$];
    logic [7:0] exp_cmd[$];
    logic [7:0] exp_data[$];
    int         act_esc = 0;
    int         act_sync = 0;
    int         exp_esc = 0;
    int         exp_sync = 0;
    logic [7:0] last_cmd = '0;
    logic [7:0] last_data = '0;

    // Collect every strobe the receiver produces
    always @(negedge clk_sys) begin
        if (!rst) begin
            if (rx_if.rx_cmd_valid) act_cmd.push_back(rx_if.rx_cmd);
            if (rx_if.rx_valid)     act_data.push_back(rx_if.rx_data);
            if (rx_if.err_esc)      act_esc++;
            if (rx_if.err_sync)     act_sync++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected)
            passes++;
        else
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    function automatic int holdLen();
        return $urandom_range(16, 6);
    endfunction

    // Line states held long enough to pass the filter are what the receiver sees
    task automatic driveLine(input lp_line_t s, input int cycles);
        @(negedge clk_sys);
        {lp_p, lp_n} = s;
        if (cycles >= FILTER_CYCLES && (sent.size() == 0 || sent[$] != s))
            sent.push_back(s);
        repeat (cycles - 1) @(negedge clk_sys);
    endtask

    task automatic sendBit(input bit b);
        driveLine(b ? LP10 : LP01, holdLen());
        driveLine(LP00, holdLen());
    endtask

    task automatic sendByte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) sendBit(v[i]);
    endtask

    task automatic sendEntry();
        driveLine(LP10, holdLen());
        driveLine(LP00, holdLen());
        driveLine(LP01, holdLen());
        driveLine(LP00, holdLen());
    endtask

    task automatic applyStimulus(input logic [7:0] cmd, input int partial, input bit mark_one);
        sendEntry();
        sendByte(cmd);
        foreach (tx_bytes[i]) sendByte(tx_bytes[i]);
        for (int p = 0; p < partial; p++) sendBit(1'($urandom_range(1, 0)));
        if (mark_one) driveLine(LP10, holdLen());
        driveLine(LP11, 20);
    endtask

    // Interpret one escape burst (symbols between two stops) as entry + bit pairs
    task automatic decodeSegment();
        lp_line_t   tail[3] = '{LP00, LP01, LP00};
        int         k;
        int         cnt;
        bit         in_data;
        logic [7:0] acc;
        k = 0;
        while (k < seg.size() && seg[k] != LP10) k++;
        if (k >= seg.size()) return;
        for (int e = 0; e < 3; e++) begin
            if (k + 1 + e >= seg.size()) return;
            if (seg[k+1+e] != tail[e]) begin
                exp_esc++;
                return;
            end
        end
        k += 4;
        cnt = 0;
        in_data = 1'b0;
        acc = '0;
        while (k + 1 < seg.size()) begin
            if (seg[k+1] != LP00) begin
                exp_esc++;
                return;
            end
            acc = {acc[6:0], seg[k] == LP10};
            cnt++;
            if (cnt == 8) begin
                cnt = 0;
                if (!in_data) begin
                    exp_cmd.push_back(acc);
                    if (acc != LPDT) return;
                    in_data = 1'b1;
                end else begin
                    exp_data.push_back(acc);
                end
            end
            k += 2;
        end
        if (cnt != 0) exp_sync++;
    endtask

    task automatic runModel();
        int i;
        exp_cmd.delete();
        exp_data.delete();
        exp_esc = 0;
        exp_sync = 0;
        i = 0;
        while (i < sent.size()) begin
            if (sent[i] == LP11) begin
                seg.delete();
                i++;
                while (i < sent.size() && sent[i] != LP11) begin
                    seg.push_back(sent[i]);
                    i++;
                end
                if (i < sent.size()) decodeSegment();
            end else begin
                i++;
            end
        end
    endtask

    task automatic clearScenario();
        sent.delete();
        sent.push_back(LP11);
        act_cmd.delete();
        act_data.delete();
        act_esc = 0;
        act_sync = 0;
    endtask

    task automatic checkScenario(input string tag);
        repeat (20) @(negedge clk_sys);
        runModel();
        checkOutput({tag, ".ncmd"}, act_cmd.size(), exp_cmd.size());
        for (int i = 0; i < exp_cmd.size() && i < act_cmd.size(); i++)
            checkOutput({tag, ".cmd"}, act_cmd[i], exp_cmd[i]);
        checkOutput({tag, ".ndata"}, act_data.size(), exp_data.size());
        for (int i = 0; i < exp_data.size() && i < act_data.size(); i++)
            checkOutput({tag, ".data"}, act_data[i], exp_data[i]);
        checkOutput({tag, ".err_esc"}, act_esc, exp_esc);
        checkOutput({tag, ".err_sync"}, act_sync, exp_sync);
        if (exp_cmd.size() > 0)  last_cmd  = exp_cmd[$];
        if (exp_data.size() > 0) last_data = exp_data[$];
        checkOutput({tag, ".rx_cmd"}, rx_if.rx_cmd, last_cmd);
        checkOutput({tag, ".rx_data"}, rx_if.rx_data, last_data);
        checkOutput({tag, ".rx_active"}, rx_if.rx_active, 0);
        clearScenario();
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, ".rx_data"}, rx_if.rx_data, 0);
        checkOutput({tag, ".rx_valid"}, rx_if.rx_valid, 0);
        checkOutput({tag, ".rx_cmd"}, rx_if.rx_cmd, 0);
        checkOutput({tag, ".rx_cmd_valid"}, rx_if.rx_cmd_valid, 0);
        checkOutput({tag, ".rx_active"}, rx_if.rx_active, 0);
        checkOutput({tag, ".err_esc"}, rx_if.err_esc, 0);
        checkOutput({tag, ".err_sync"}, rx_if.err_sync, 0);
    endtask

    initial begin
        logic [7:0] cmd;
        int         nb;
        int         partial;

        rst = 1'b1;
        lines_enable = 1'b1;
        {lp_p, lp_n} = 2'b11;
        repeat (5) @(negedge clk_sys);
        checkResetOutputs("por");
        rst = 1'b0;
        repeat (10) @(negedge clk_sys);
        clearScenario();

        // LPDT frame with two bytes closed by mark-one
        sendEntry();
        checkOutput("t1.active", rx_if.rx_active, 1);
        sendByte(LPDT);
        sendByte(8'h5A);
        sendByte(8'hC3);
        driveLine(LP10, holdLen());
        driveLine(LP11, 20);
        repeat (5) @(negedge clk_sys);
        checkOutput("t1.byte0", (act_data.size() > 0) ? act_data[0] : 8'h00, 8'h5A);
        checkOutput("t1.byte1", (act_data.size() > 1) ? act_data[1] : 8'h00, 8'hC3);
        checkScenario("t1");

        // Non-LPDT command followed by ignored bits
        tx_bytes = '{8'hA7};
        applyStimulus(8'h62, 0, 1'b1);
        checkScenario("t2");

        // Escape request that skips LP-00
        driveLine(LP10, 12);
        driveLine(LP01, 12);
        driveLine(LP11, 20);
        checkScenario("t3");

        // Stop after three bits of a data byte
        tx_bytes = '{8'h3C};
        applyStimulus(LPDT, 3, 1'b0);
        checkScenario("t4");

        // Short LP-00 glitch during idle
        driveLine(LP00, 2);
        driveLine(LP11, 10);
        checkOutput("t5.active", rx_if.rx_active, 0);
        checkScenario("t5");

        // Reset in the middle of a data byte
        sendEntry();
        sendByte(LPDT);
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        @(negedge clk_sys);
        rst = 1'b1;
        {lp_p, lp_n} = 2'b11;
        repeat (2) @(negedge clk_sys);
        checkResetOutputs("t6.rst");
        repeat (3) @(negedge clk_sys);
        rst = 1'b0;
        last_cmd = '0;
        last_data = '0;
        repeat (10) @(negedge clk_sys);
        clearScenario();
        tx_bytes = '{8'h96, 8'h0F};
        applyStimulus(LPDT, 0, 1'b1);
        checkScenario("t6");

        // Disabling the lane mid-frame suppresses all strobes
        sendEntry();
        sendByte(LPDT);
        sendBit(1'b1);
        sendBit(1'b1);
        @(negedge clk_sys);
        lines_enable = 1'b0;
        repeat (2) @(negedge clk_sys);
        checkOutput("t7.active", rx_if.rx_active, 0);
        checkOutput("t7.cmd_seen", act_cmd.size(), 1);
        act_cmd.delete();
        act_data.delete();
        act_esc = 0;
        act_sync = 0;
        sendByte(8'($urandom_range(255, 0)));
        driveLine(LP11, 20);
        checkOutput("t7.pulses", act_cmd.size() + act_data.size() + act_esc + act_sync, 0);
        lines_enable = 1'b1;
        last_cmd = LPDT;
        repeat (5) @(negedge clk_sys);
        clearScenario();

        // Random frames
        for (int f = 0; f < 8; f++) begin
            cmd = ($urandom_range(1, 0) == 1) ? LPDT : 8'($urandom_range(255, 0));
            tx_bytes.delete();
            nb = $urandom_range(3, 0);
            for (int b = 0; b < nb; b++) tx_bytes.push_back(8'($urandom_range(255, 0)));
            partial = ($urandom_range(3, 0) == 0) ? $urandom_range(7, 1) : 0;
            applyStimulus(cmd, partial, 1'($urandom_range(1, 0)));
            checkScenario("rand");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
